// File: rtl/cdc_req_arbiter_pkg.sv
// Shared definitions for the CDC request arbiter: FSM state encoding and a
// width helper.
package cdc_req_arbiter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Index width for n items; never narrower than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_req_arbiter_sync.sv
// Multi-flop synchroniser for signals arriving from another clock domain.
module gen_ticks_sync
  import cdc_req_arbiter_pkg::*;
#(
  parameter int DP = 2,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] r_stage [DP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DP; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d_i;
      for (int i = 1; i < DP; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q_o = r_stage[DP-1];

endmodule

// File: rtl/cdc_req_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel between NREQ
// local requesters; the remote ack is only ever seen through the synchroniser.
//
//   state   | meaning
//   IDLE    | waiting for a valid requester and a low synchronised ack
//   REQ     | cdc_req_o high, data held, waiting for ack to rise
//   ACK     | cdc_req_o low, waiting for ack to fall before completing
module cdc_req_arbiter
  import cdc_req_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int DW   = 32,
  parameter int DP   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DW-1:0]       req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     cdc_req_o,
  output logic [DW-1:0]            cdc_data_o,
  input  logic                     cdc_ack_i,
  output logic [clog2(NREQ)-1:0]   grant_id_o,
  output logic                     busy_o,
  output logic                     xfer_done_o
);

  localparam int IW = clog2(NREQ);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_cdc_req;
  logic [DW-1:0] r_cdc_data;
  logic [IW-1:0] r_grant_id;
  logic          w_ack_s;
  logic [IW-1:0] w_pick;
  logic          w_accept;

  gen_ticks_sync #(.DP(DP), .DW(1)) u_ack_sync (
    .clk   (clk),
    .rst_n (~rst),
    .d_i   (cdc_ack_i),
    .q_o   (w_ack_s)
  );

  // Lowest valid above the last grant wins; otherwise wrap to the lowest valid.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   last);
    logic [NREQ-1:0] masked;
    logic            found;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) masked[k] = v[k] && (k > int'(last));
    for (int k = 0; k < NREQ; k++) begin
      if (masked[k] && !found) begin
        rr_pick = IW'(k);
        found   = 1'b1;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (v[k] && !found) begin
        rr_pick = IW'(k);
        found   = 1'b1;
      end
    end
  endfunction

  assign w_pick   = rr_pick(req_valid_i, r_grant_id);
  assign w_accept = (r_state == ST_IDLE) && !w_ack_s && (|req_valid_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_REQ;
      ST_REQ:  if (w_ack_s)  w_state_nxt = ST_ACK;
      ST_ACK:  if (!w_ack_s) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (w_accept && !rst) req_ready_o[w_pick] = 1'b1;
    busy_o      = (r_state != ST_IDLE);
    xfer_done_o = (r_state == ST_ACK) && !w_ack_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdc_req  <= 1'b0;
      r_cdc_data <= '0;
      r_grant_id <= IW'(NREQ - 1);
    end else if (w_accept) begin
      r_cdc_req  <= 1'b1;
      r_cdc_data <= req_data_i[int'(w_pick)*DW +: DW];
      r_grant_id <= w_pick;
    end else if ((r_state == ST_REQ) && w_ack_s) begin
      r_cdc_req  <= 1'b0;
    end
  end

  assign cdc_req_o  = r_cdc_req;
  assign cdc_data_o = r_cdc_data;
  assign grant_id_o = r_grant_id;

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Bench for cdc_req_arbiter: a phase-level model checked every cycle, a random
// remote responder, and directed scenarios with literal expectations.
module tb_cdc_req_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int DP   = 2;
  localparam int IW   = 1;
  localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid_i;
  logic [NREQ*DW-1:0]  req_data_i;
  logic [NREQ-1:0]     req_ready_o;
  logic                cdc_req_o;
  logic [DW-1:0]       cdc_data_o;
  logic                cdc_ack_i;
  logic [IW-1:0]       grant_id_o;
  logic                busy_o;
  logic                xfer_done_o;

  always #5 clk = ~clk;

  cdc_req_arbiter #(.NREQ(NREQ), .DW(DW), .DP(DP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .cdc_req_o   (cdc_req_o),
    .cdc_data_o  (cdc_data_o),
    .cdc_ack_i   (cdc_ack_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o),
    .xfer_done_o (xfer_done_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Remote side: ack follows req after 1..5 cycles unless forced.
  logic force_on  = 1'b0;
  logic force_val = 1'b0;
  int   dly       = 0;
  initial begin
    cdc_ack_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (force_on) begin
        cdc_ack_i = force_val;
        dly = 0;
      end else if (cdc_ack_i != cdc_req_o) begin
        if (dly == 0) dly = $urandom_range(1, 5);
        dly--;
        if (dly == 0) cdc_ack_i = cdc_req_o;
      end else begin
        dly = 0;
      end
    end
  end

  // Model: transfer phase, last grant, held word, and ack delayed DP cycles.
  int            m_phase;
  logic [IW-1:0] m_gid;
  logic [DW-1:0] m_data;
  logic          hist [1:DP];
  int            wait_cnt [NREQ];
  int            max_wait = 0;
  int            n_grant  = 0;
  int            n_done   = 0;

  initial begin
    logic            acks;
    logic            go;
    logic            found;
    int              pick;
    int              k;
    logic [NREQ-1:0] exp_ready;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_phase = P_IDLE;
        m_gid   = IW'(NREQ - 1);
        m_data  = '0;
        for (int i = 1; i <= DP; i++) hist[i] = 1'b0;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        max_wait = 0;
        chk("rst_ready", 64'(req_ready_o), 64'd0);
        chk("rst_req",   64'(cdc_req_o),   64'd0);
        chk("rst_data",  64'(cdc_data_o),  64'd0);
        chk("rst_gid",   64'(grant_id_o),  64'(NREQ - 1));
        chk("rst_busy",  64'(busy_o),      64'd0);
        chk("rst_done",  64'(xfer_done_o), 64'd0);
      end else begin
        acks  = hist[DP];
        found = 1'b0;
        pick  = 0;
        for (int i = 1; i <= NREQ; i++) begin
          k = (int'(m_gid) + i) % NREQ;
          if (req_valid_i[k] && !found) begin
            pick  = k;
            found = 1'b1;
          end
        end
        go = (m_phase == P_IDLE) && !acks && found;
        exp_ready = '0;
        if (go) exp_ready[pick] = 1'b1;
        chk("ready", 64'(req_ready_o), 64'(exp_ready));
        chk("req",   64'(cdc_req_o),   64'(m_phase == P_REQ));
        chk("data",  64'(cdc_data_o),  64'(m_data));
        chk("gid",   64'(grant_id_o),  64'(m_gid));
        chk("busy",  64'(busy_o),      64'(m_phase != P_IDLE));
        chk("done",  64'(xfer_done_o), 64'((m_phase == P_ACK) && !acks));
        if (|req_ready_o) n_grant++;
        if (xfer_done_o)  n_done++;
        if (go) begin
          for (int i = 0; i < NREQ; i++) begin
            if (i == pick) wait_cnt[i] = 0;
            else if (req_valid_i[i]) begin
              wait_cnt[i]++;
              if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end else wait_cnt[i] = 0;
          end
        end
        case (m_phase)
          P_IDLE: if (go) begin
            m_data  = req_data_i[pick*DW +: DW];
            m_gid   = IW'(pick);
            m_phase = P_REQ;
          end
          P_REQ:  if (acks)  m_phase = P_ACK;
          default: if (!acks) m_phase = P_IDLE;
        endcase
        for (int i = DP; i > 1; i--) hist[i] = hist[i-1];
        hist[1] = cdc_ack_i;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    force_on    = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (xfer_done_o) break;
    end
    chk(name, 64'(i < budget), 64'd1);
  endtask

  task automatic wait_ready(input string name, input int budget, output logic [NREQ-1:0] seen);
    int i;
    seen = '0;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (|req_ready_o) begin
        seen = req_ready_o;
        break;
      end
    end
    chk(name, 64'(i < budget), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] seen;
    logic [DW-1:0]   words [NREQ];
    int              cnt;
    int              g0, d0;
    rst = 1'b1;
    req_valid_i = '0;
    req_data_i  = '0;
    do_reset();

    // 1: single transfer
    @(posedge clk); #1;
    req_valid_i = 2'b01;
    req_data_i[0 +: DW] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t1_ready", 64'(req_ready_o), 64'h1);
    @(posedge clk); #1;
    req_valid_i = '0;
    req_data_i  = '0;
    @(negedge clk);
    chk("t1_req",  64'(cdc_req_o),  64'd1);
    chk("t1_data", 64'(cdc_data_o), 64'hDEAD_BEEF);
    wait_done("t1_done", 60);
    chk("t1_gid",  64'(grant_id_o), 64'd0);
    chk("t1_hold", 64'(cdc_data_o), 64'hDEAD_BEEF);

    // 2: contention, alternating grants from reset
    do_reset();
    words[0] = 32'hA0A0_0000;
    words[1] = 32'hB1B1_1111;
    @(posedge clk); #1;
    req_valid_i = 2'b11;
    req_data_i  = {words[1], words[0]};
    for (int t = 0; t < 4; t++) begin
      wait_ready("t2_ready_seen", 60, seen);
      chk("t2_order", 64'(seen), 64'(t % 2 == 0 ? 2'b01 : 2'b10));
      @(negedge clk);
      chk("t2_data", 64'(cdc_data_o), 64'(words[t % 2]));
      wait_done("t2_done", 60);
    end
    @(posedge clk); #1;
    req_valid_i = '0;

    // 3: stale ack blocks grants until it falls and crosses the synchroniser
    do_reset();
    @(negedge clk);
    force_on  = 1'b1;
    force_val = 1'b1;
    repeat (DP + 2) @(posedge clk);
    #1 req_valid_i = 2'b10;
    for (int t = 0; t < DP + 3; t++) begin
      @(negedge clk);
      chk("t3_blocked", 64'(req_ready_o), 64'd0);
    end
    force_val = 1'b0;
    @(posedge clk); #2;
    repeat (DP - 1) @(posedge clk);
    @(negedge clk);
    chk("t3_still_blocked", 64'(req_ready_o), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t3_ready1", 64'(req_ready_o), 64'h2);
    @(posedge clk); #1;
    req_valid_i = '0;
    force_on    = 1'b0;
    wait_done("t3_done", 60);

    // 4: reset during REQ aborts without completion
    do_reset();
    @(posedge clk); #1;
    req_valid_i = 2'b01;
    req_data_i[0 +: DW] = 32'h1234_5678;
    cnt = 0;
    while (!cdc_req_o && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("t4_in_req", 64'(cdc_req_o), 64'd1);
    d0 = n_done;
    @(posedge clk); #1;
    req_valid_i = '0;
    rst = 1'b1;
    #1;
    chk("t4_req_async",  64'(cdc_req_o), 64'd0);
    chk("t4_busy_async", 64'(busy_o),    64'd0);
    @(negedge clk);
    chk("t4_gid",  64'(grant_id_o),  64'd1);
    chk("t4_data", 64'(cdc_data_o),  64'd0);
    chk("t4_done", 64'(xfer_done_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_no_done", 64'(n_done - d0), 64'd0);

    // 5: valid[1] raised and withdrawn during REQ is never accepted
    do_reset();
    @(posedge clk); #1;
    req_valid_i = 2'b01;
    req_data_i  = {32'h5555_5555, 32'h0BAD_F00D};
    @(negedge clk);
    chk("t5_ready0", 64'(req_ready_o), 64'h1);
    @(posedge clk); #1;
    req_valid_i = 2'b10;
    @(posedge clk); #1;
    req_valid_i = 2'b00;
    cnt = 0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (req_ready_o[1]) cnt++;
      if (xfer_done_o) break;
    end
    repeat (4) begin
      @(negedge clk);
      if (req_ready_o[1]) cnt++;
    end
    chk("t5_no_ready1", 64'(cnt), 64'd0);
    chk("t5_data", 64'(cdc_data_o), 64'h0BAD_F00D);

    // 6: random traffic
    do_reset();
    g0 = n_grant;
    d0 = n_done;
    for (int t = 0; t < 10000; t++) begin
      @(posedge clk); #1;
      req_valid_i = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) req_data_i[i*DW +: DW] = $urandom;
    end
    @(posedge clk); #1;
    req_valid_i = '0;
    cnt = 0;
    while ((busy_o || cdc_ack_i) && cnt < 80) begin
      @(negedge clk);
      cnt++;
    end
    chk("t6_quiesce", 64'(cnt < 80), 64'd1);
    chk("t6_done_per_grant", 64'(n_done - d0), 64'(n_grant - g0));
    chk("t6_traffic", 64'((n_grant - g0) > 200), 64'd1);
    chk("t6_starve", 64'(max_wait <= NREQ - 1), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
